// File: rtl/ean13_renderer.sv
// EAN-13 barcode renderer: draws a 13-digit BCD code as 1-bit bars into an active video stream.
// The code is double-buffered and only swaps at frame start, so a frame never shows a mixed code.
module ean13_renderer #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned X_OFFSET     = 16,
   parameter int unsigned MODULE_WIDTH = 3,
   parameter int unsigned Y_START      = 8,
   parameter int unsigned BAR_HEIGHT   = 64,
   parameter logic        BAR_LEVEL    = 1'b0
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iPixelSync,
   input  logic        iPixelActive,
   input  logic [51:0] iDataCode,
   input  logic        iLoad,
   output logic        oPixelSync,
   output logic        oPixelActive,
   output logic        oPixelData,
   output logic        oCodeError
);
   localparam int unsigned XW = $clog2(H_ACTIVE + 1);
   localparam int unsigned YW = 16;
   localparam int unsigned MW = 4;

   typedef enum logic [2:0] {QUIET, LGUARD, LEFT, MGUARD, RIGHT, RGUARD, DONE} lineStateT;

   lineStateT     state, stateNext, curState;
   logic [XW-1:0] xCnt, xNext;
   logic [YW-1:0] yCnt, yNext;
   logic [MW-1:0] modCnt, modNext;
   logic [2:0]    bitCnt, bitNext, digitCnt, digitNext;
   logic [51:0]   pendingCode, shadowCode, syncCode;
   logic [7:0]    checkSum, checkRem;
   logic [3:0]    checkWant, curDigit;
   logic [5:0]    digitBase, parityBits;
   logic [6:0]    pattern;
   logic          frameLive, codeBad, pixelNext, lineFall, inWindow, inSymbol, barBit, elemLast;

   function automatic logic [6:0] lCode(input logic [3:0] d);
      case (d)
         4'd0:    lCode = 7'b0001101;
         4'd1:    lCode = 7'b0011001;
         4'd2:    lCode = 7'b0010011;
         4'd3:    lCode = 7'b0111101;
         4'd4:    lCode = 7'b0100011;
         4'd5:    lCode = 7'b0110001;
         4'd6:    lCode = 7'b0101111;
         4'd7:    lCode = 7'b0111011;
         4'd8:    lCode = 7'b0110111;
         4'd9:    lCode = 7'b0001011;
         default: lCode = 7'b0000000;
      endcase
   endfunction

   // One bit per left digit (d2 first in the MSB), 1 selects the G set
   function automatic logic [5:0] parityOf(input logic [3:0] d);
      case (d)
         4'd1:    parityOf = 6'b001011;
         4'd2:    parityOf = 6'b001101;
         4'd3:    parityOf = 6'b001110;
         4'd4:    parityOf = 6'b010011;
         4'd5:    parityOf = 6'b011001;
         4'd6:    parityOf = 6'b011100;
         4'd7:    parityOf = 6'b010101;
         4'd8:    parityOf = 6'b010110;
         4'd9:    parityOf = 6'b011010;
         default: parityOf = 6'b000000;
      endcase
   endfunction

   function automatic logic [6:0] reverse7(input logic [6:0] v);
      for (int i = 0; i < 7; i++) reverse7[i] = v[6-i];
   endfunction

   assign syncCode = iLoad ? iDataCode : pendingCode;
   assign lineFall = oPixelActive && !iPixelActive;
   assign inWindow = ({1'b0, yCnt} >= 17'(Y_START)) && ({1'b0, yCnt} < 17'(Y_START + BAR_HEIGHT));

   // Validity of the code that becomes the frame's code at the next sync
   always_comb begin
      checkSum = '0;
      codeBad  = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (syncCode[4*(13-k) +: 4] > 4'd9) codeBad = 1'b1;
         checkSum = checkSum + 8'(syncCode[4*(13-k) +: 4]) * ((k % 2 == 0) ? 8'd3 : 8'd1);
      end
      checkRem  = checkSum % 8'd10;
      checkWant = (checkRem == 8'd0) ? 4'd0 : 4'(8'd10 - checkRem);
      if (syncCode[3:0] > 4'd9 || syncCode[3:0] != checkWant) codeBad = 1'b1;
   end

   // Current element and bar bit; the QUIET->LGUARD hand-off happens on the first guard pixel itself
   always_comb begin
      curState = state;
      if (state == QUIET && xCnt == XW'(X_OFFSET)) curState = LGUARD;
      inSymbol   = (curState != QUIET) && (curState != DONE);
      digitBase  = (curState == LEFT) ? 6'd44 - {1'b0, digitCnt, 2'b00} : 6'd20 - {1'b0, digitCnt, 2'b00};
      curDigit   = shadowCode[digitBase +: 4];
      parityBits = parityOf(shadowCode[51:48]);
      pattern    = ~lCode(curDigit);
      if (curState == LEFT)
         pattern = parityBits[3'd5 - digitCnt] ? reverse7(~lCode(curDigit)) : lCode(curDigit);
      barBit   = 1'b0;
      elemLast = 1'b0;
      case (curState)
         LGUARD, RGUARD: begin barBit = (bitCnt != 3'd1); elemLast = (bitCnt == 3'd2); end
         MGUARD:         begin barBit = bitCnt[0];        elemLast = (bitCnt == 3'd4); end
         LEFT, RIGHT:    begin barBit = pattern[3'd6 - bitCnt]; elemLast = (bitCnt == 3'd6); end
         default:        ;
      endcase
   end

   // Next-state and counter update
   always_comb begin
      stateNext = state;
      xNext     = xCnt;
      yNext     = yCnt;
      modNext   = modCnt;
      bitNext   = bitCnt;
      digitNext = digitCnt;
      if (iPixelSync || lineFall) begin
         stateNext = QUIET;
         xNext     = '0;
         modNext   = '0;
         bitNext   = '0;
         digitNext = '0;
         if (iPixelSync)       yNext = '0;
         else if (yCnt != '1)  yNext = yCnt + 1'b1;
      end else if (iPixelActive) begin
         if (xCnt != XW'(H_ACTIVE)) xNext = xCnt + 1'b1;
         if (inSymbol) begin
            stateNext = curState;
            if (modCnt == MW'(MODULE_WIDTH - 1)) begin
               modNext = '0;
               if (elemLast) begin
                  bitNext = '0;
                  case (curState)
                     LGUARD: begin stateNext = LEFT; digitNext = '0; end
                     LEFT:   if (digitCnt == 3'd5) begin stateNext = MGUARD; digitNext = '0; end
                             else digitNext = digitCnt + 1'b1;
                     MGUARD: begin stateNext = RIGHT; digitNext = '0; end
                     RIGHT:  if (digitCnt == 3'd5) begin stateNext = RGUARD; digitNext = '0; end
                             else digitNext = digitCnt + 1'b1;
                     RGUARD: stateNext = DONE;
                     default: ;
                  endcase
               end else begin
                  bitNext = bitCnt + 1'b1;
               end
            end else begin
               modNext = modCnt + 1'b1;
            end
         end
      end
      pixelNext = (frameLive && !oCodeError && !iPixelSync && iPixelActive && inWindow && inSymbol && barBit)
                  ? BAR_LEVEL : ~BAR_LEVEL;
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state        <= QUIET;
         xCnt         <= '0;
         yCnt         <= '0;
         modCnt       <= '0;
         bitCnt       <= '0;
         digitCnt     <= '0;
         pendingCode  <= '0;
         shadowCode   <= '0;
         frameLive    <= 1'b0;
         oPixelSync   <= 1'b0;
         oPixelActive <= 1'b0;
         oPixelData   <= ~BAR_LEVEL;
         oCodeError   <= 1'b0;
      end else begin
         state        <= stateNext;
         xCnt         <= xNext;
         yCnt         <= yNext;
         modCnt       <= modNext;
         bitCnt       <= bitNext;
         digitCnt     <= digitNext;
         if (iLoad) pendingCode <= iDataCode;
         if (iPixelSync) begin
            shadowCode <= syncCode;
            oCodeError <= codeBad;
            frameLive  <= 1'b1;
         end
         oPixelSync   <= iPixelSync;
         oPixelActive <= iPixelActive;
         oPixelData   <= pixelNext;
      end
   end
endmodule
